rnn_mac_fetch: RTL and testbench

RNN_MAC_FETCH -- requirements
Module: rnn_mac_fetch

---
 rtl/rnn_mac_fetch_if.sv | 23 ++
 rtl/rnn_mac_fetch.sv | 84 ++++++++
 tb/tb_rnn_mac_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rnn_mac_fetch_if.sv
// rtl/rnn_mac_fetch_if.sv - control, activation stream, weight ROM and result handshake bundle
interface rnn_mac_fetch_if;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    modport master (
        output start, in_data, in_valid, rom_data, out_ready,
        input  in_ready, rom_addr, out_data, out_valid, busy
    );

    modport slave (
        input  start, in_data, in_valid, rom_data, out_ready,
        output in_ready, rom_addr, out_data, out_valid, busy
    );
endinterface

// File: rtl/rnn_mac_fetch.sv
// rtl/rnn_mac_fetch.sv - dot product of streamed activations with a combinational weight ROM
module rnn_mac_fetch #(
    parameter int LEN = 16
) (
    input logic          clk,
    input logic          rst,
    rnn_mac_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(LEN - 1);

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [19:0] acc, acc_nx;
    logic [19:0] res, res_nx;
    logic [15:0] prod;
    logic [19:0] sum;

    // The ROM is combinational, so the weight for idx is available in the same cycle.
    assign prod = 16'(bus.in_data) * 16'(bus.rom_data);
    assign sum  = acc + {4'b0000, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 4'd0;
            acc   <= 20'd0;
            res   <= 20'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            acc   <= acc_nx;
            res   <= res_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        acc_nx   = acc;
        res_nx   = res;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                    idx_nx   = 4'd0;
                    acc_nx   = 20'd0;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    acc_nx = sum;
                    if (idx == LAST_IDX) begin
                        state_nx = DONE;
                        res_nx   = sum;
                        idx_nx   = 4'd0;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
            end
            DONE: begin
                // start arriving with the handshake is dropped; only IDLE honours it
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state == RUN);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.rom_addr  = idx;
    assign bus.out_data  = res;
endmodule

// File: tb/tb_rnn_mac_fetch.sv
// tb/tb_rnn_mac_fetch.sv - self-checking bench for rnn_mac_fetch at LEN 16, 4, 1 and 2
module tb_rnn_mac_fetch;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] wrom [16] = '{8'd0, 8'd1, 8'd6, 8'd11, 8'd20, 8'd37, 8'd70, 8'd135,
                              8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    int lens [4] = '{16, 4, 1, 2};

    always #5 clk = ~clk;

    rnn_mac_fetch_if b0 ();
    rnn_mac_fetch_if b1 ();
    rnn_mac_fetch_if b2 ();
    rnn_mac_fetch_if b3 ();

    logic        rdy [4];
    logic        ov  [4];
    logic        bz  [4];
    logic [3:0]  ra  [4];
    logic [19:0] od  [4];

    assign b0.start = start;  assign b0.in_data = in_data;  assign b0.in_valid = in_valid;  assign b0.out_ready = out_ready;
    assign b1.start = start;  assign b1.in_data = in_data;  assign b1.in_valid = in_valid;  assign b1.out_ready = out_ready;
    assign b2.start = start;  assign b2.in_data = in_data;  assign b2.in_valid = in_valid;  assign b2.out_ready = out_ready;
    assign b3.start = start;  assign b3.in_data = in_data;  assign b3.in_valid = in_valid;  assign b3.out_ready = out_ready;
    assign b0.rom_data = wrom[b0.rom_addr];
    assign b1.rom_data = wrom[b1.rom_addr];
    assign b2.rom_data = wrom[b2.rom_addr];
    assign b3.rom_data = wrom[b3.rom_addr];

    assign rdy[0] = b0.in_ready;  assign ov[0] = b0.out_valid;  assign bz[0] = b0.busy;  assign ra[0] = b0.rom_addr;  assign od[0] = b0.out_data;
    assign rdy[1] = b1.in_ready;  assign ov[1] = b1.out_valid;  assign bz[1] = b1.busy;  assign ra[1] = b1.rom_addr;  assign od[1] = b1.out_data;
    assign rdy[2] = b2.in_ready;  assign ov[2] = b2.out_valid;  assign bz[2] = b2.busy;  assign ra[2] = b2.rom_addr;  assign od[2] = b2.out_data;
    assign rdy[3] = b3.in_ready;  assign ov[3] = b3.out_valid;  assign bz[3] = b3.busy;  assign ra[3] = b3.rom_addr;  assign od[3] = b3.out_data;

    rnn_mac_fetch #(.LEN(16)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    rnn_mac_fetch #(.LEN(4))  dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    rnn_mac_fetch #(.LEN(1))  dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    rnn_mac_fetch #(.LEN(2))  dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    // Reference: phase 0 waiting, 1 collecting beats, 2 presenting; result is the weighted sum of beats.
    int ph  [4];
    int cnt [4];
    int part[4];
    int res [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                ph[k] = 0; cnt[k] = 0; part[k] = 0; res[k] = 0;
            end else if (ph[k] == 0) begin
                if (start) begin
                    ph[k] = 1; cnt[k] = 0; part[k] = 0;
                end
            end else if (ph[k] == 1) begin
                if (in_valid) begin
                    part[k] = part[k] + int'(in_data) * int'(wrom[cnt[k]]);
                    if (cnt[k] + 1 == lens[k]) begin
                        ph[k] = 2; res[k] = part[k]; cnt[k] = 0;
                    end else begin
                        cnt[k] = cnt[k] + 1;
                    end
                end
            end else begin
                if (out_ready) ph[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d%0d.in_ready", k),  int'(rdy[k]), int'(ph[k] == 1));
            chk($sformatf("d%0d.out_valid", k), int'(ov[k]),  int'(ph[k] == 2));
            chk($sformatf("d%0d.busy", k),      int'(bz[k]),  int'(ph[k] != 0));
            chk($sformatf("d%0d.rom_addr", k),  int'(ra[k]),  cnt[k]);
            chk($sformatf("d%0d.out_data", k),  int'(od[k]),  res[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        int k;
        int val;
        int stall_at;
        int stall_n;
        int hold;
        int rst_first;
        int exp;
    } vec_t;

    task automatic run_op(input vec_t r);
        if (r.rst_first != 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
        end
        out_ready = (r.hold == 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int b = 0; b < lens[r.k]; b++) begin
            if (b == r.stall_at) begin
                in_valid = 1'b0;
                for (int s = 0; s < r.stall_n; s++) begin
                    tick();
                    chk("stall.rom_addr", int'(ra[r.k]), r.stall_at);
                end
            end
            in_valid = 1'b1;
            in_data  = 8'(r.val);
            tick();
        end
        in_valid = 1'b0;
        chk("op.out_valid_entry", int'(ov[r.k]), 1);
        chk("op.out_data", int'(od[r.k]), r.exp);
        for (int h = 0; h < r.hold; h++) begin
            start = (h == 2);
            tick();
            start = 1'b0;
            chk("hold.out_valid", int'(ov[r.k]), 1);
            chk("hold.out_data", int'(od[r.k]), r.exp);
        end
        out_ready = 1'b1;
        tick();
        chk("op.out_valid_after", int'(ov[r.k]), 0);
        chk("op.busy_after", int'(bz[r.k]), 0);
    endtask

    vec_t tbl [6];
    vec_t again;

    initial begin
        tbl[0] = '{k: 0, val: 1,   stall_at: -1, stall_n: 0, hold: 0, rst_first: 1, exp: 372};
        tbl[1] = '{k: 0, val: 255, stall_at: -1, stall_n: 0, hold: 0, rst_first: 1, exp: 94860};
        tbl[2] = '{k: 1, val: 1,   stall_at: 2,  stall_n: 3, hold: 0, rst_first: 1, exp: 18};
        tbl[3] = '{k: 0, val: 1,   stall_at: -1, stall_n: 0, hold: 5, rst_first: 1, exp: 372};
        tbl[4] = '{k: 2, val: 200, stall_at: -1, stall_n: 0, hold: 0, rst_first: 1, exp: 0};
        tbl[5] = '{k: 3, val: 200, stall_at: -1, stall_n: 0, hold: 0, rst_first: 1, exp: 200};
        again  = '{k: 0, val: 1,   stall_at: -1, stall_n: 0, hold: 0, rst_first: 0, exp: 372};

        for (int k = 0; k < 4; k++) begin
            ph[k] = 0; cnt[k] = 0; part[k] = 0; res[k] = 0;
        end

        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        rst = 1'b0;
        chk("reset.busy", int'(bz[0]), 0);
        chk("reset.out_data", int'(od[0]), 0);

        for (int i = 0; i < 6; i++) run_op(tbl[i]);

        // abort after 7 beats; reset wins over a concurrent beat
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            in_valid = 1'b1; in_data = 8'd1; tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("abort.busy", int'(bz[0]), 0);
        chk("abort.rom_addr", int'(ra[0]), 0);
        chk("abort.out_valid", int'(ov[0]), 0);
        run_op(again);

        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 3) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
